// File: rtl/image_loader_pkg.sv
// Shared definitions for the image loader and the video/sprite memories it feeds.
// The default limits also size the background and spritesheet memories.
package image_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_WORD,
        EMIT,
        FULL
    } state_t;

    localparam logic TARGET_BACKGROUND  = 1'b0;
    localparam logic TARGET_SPRITESHEET = 1'b1;

    localparam logic [16:0] BACKGROUND_WORDS_DEFAULT  = 17'd129600;
    localparam logic [16:0] SPRITESHEET_BYTES_DEFAULT = 17'd32768;

    localparam int BG_LANE_W = 16;
    localparam int SP_LANE_W = 8;

endpackage

// File: rtl/image_loader_word_serializer.sv
// Holds the lanes of a 32-bit word that are still to be written, MSB lane first.
// Lane 0 is taken straight from the input word, so the register keeps lanes 1..N-1.
module word_serializer #(
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [31:0]       load_data,
    input  logic              advance,
    output logic [LANE_W-1:0] next_lane_data,
    output logic              last_lane
);
    localparam int LANES   = 32 / LANE_W;
    localparam int LANE_CW = $clog2(LANES);

    logic [31:0]        r_shift;
    logic [LANE_CW-1:0] r_lane;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_lane  <= '0;
        end else if (load) begin
            r_shift <= load_data << LANE_W;
            r_lane  <= '0;
        end else if (advance) begin
            r_shift <= r_shift << LANE_W;
            r_lane  <= r_lane + LANE_CW'(1);
        end
    end

    // r_lane is the lane currently on the write bus.
    assign next_lane_data = r_shift[31 -: LANE_W];
    assign last_lane      = (r_lane == LANE_CW'(LANES - 1));

endmodule

// File: rtl/image_loader.sv
// Serialises 32-bit upstream words into background (RGB565) or spritesheet (alpha)
// write strobes, counting addresses up to the image size and flagging done/overflow.
module image_loader
    import image_loader_pkg::*;
#(
    parameter logic [16:0] BACKGROUND_WORDS  = BACKGROUND_WORDS_DEFAULT,
    parameter logic [16:0] SPRITESHEET_BYTES = SPRITESHEET_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        target,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        background_write_en,
    output logic        spritesheet_write_en,
    output logic [16:0] image_write_addr,
    output logic [15:0] image_write_data,
    output logic        busy,
    output logic        done,
    output logic        overflow
);
    state_t      r_state;
    logic        r_target;
    logic [16:0] r_addr_cnt;
    logic        r_bg_en;
    logic        r_sp_en;
    logic [16:0] r_addr;
    logic [15:0] r_data;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;
    logic        r_ready;

    logic                 w_handshake;
    logic                 w_load;
    logic                 w_issue_next;
    logic                 w_limit_hit;
    logic                 w_last_lane;
    logic                 w_is_sprite;
    logic [16:0]          w_limit;
    logic [BG_LANE_W-1:0] w_bg_lane;
    logic [SP_LANE_W-1:0] w_sp_lane;
    logic                 w_bg_last;
    logic                 w_sp_last;
    logic [15:0]          w_first_data;
    logic [15:0]          w_next_data;

    // A start in the same cycle always wins over a pending handshake.
    assign in_ready     = r_ready & ~start;
    assign w_handshake  = in_valid & in_ready;
    assign w_is_sprite  = (r_target == TARGET_SPRITESHEET);
    assign w_limit      = w_is_sprite ? SPRITESHEET_BYTES : BACKGROUND_WORDS;
    assign w_limit_hit  = (r_addr_cnt == w_limit);
    assign w_last_lane  = w_is_sprite ? w_sp_last : w_bg_last;
    assign w_load       = (r_state == WAIT_WORD) & w_handshake;
    assign w_issue_next = (r_state == EMIT) & ~start & ~w_limit_hit & ~w_last_lane;
    assign w_first_data = w_is_sprite ? {8'h00, in_data[31:24]} : in_data[31:16];
    assign w_next_data  = w_is_sprite ? {8'h00, w_sp_lane} : w_bg_lane;

    word_serializer #(.LANE_W(BG_LANE_W)) u_bg_ser (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (w_load),
        .load_data      (in_data),
        .advance        (w_issue_next),
        .next_lane_data (w_bg_lane),
        .last_lane      (w_bg_last)
    );

    word_serializer #(.LANE_W(SP_LANE_W)) u_sp_ser (
        .clk            (clk),
        .reset_n        (reset_n),
        .load           (w_load),
        .load_data      (in_data),
        .advance        (w_issue_next),
        .next_lane_data (w_sp_lane),
        .last_lane      (w_sp_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_target   <= TARGET_BACKGROUND;
            r_addr_cnt <= '0;
            r_bg_en    <= 1'b0;
            r_sp_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b0;
        end else if (start) begin
            r_state    <= WAIT_WORD;
            r_target   <= target;
            r_addr_cnt <= '0;
            r_bg_en    <= 1'b0;
            r_sp_en    <= 1'b0;
            r_addr     <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_bg_en <= 1'b0;
            r_sp_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b0;
                end
                WAIT_WORD: begin
                    if (w_handshake) begin
                        r_state    <= EMIT;
                        r_ready    <= 1'b0;
                        r_bg_en    <= ~w_is_sprite;
                        r_sp_en    <= w_is_sprite;
                        r_addr     <= r_addr_cnt;
                        r_data     <= w_first_data;
                        r_addr_cnt <= r_addr_cnt + 17'd1;
                    end
                end
                EMIT: begin
                    // Hitting the limit mid-word discards the remaining lanes.
                    if (w_limit_hit) begin
                        r_state    <= FULL;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_ready    <= 1'b1;
                        r_overflow <= ~w_last_lane;
                    end else if (w_last_lane) begin
                        r_state <= WAIT_WORD;
                        r_ready <= 1'b1;
                    end else begin
                        r_bg_en    <= ~w_is_sprite;
                        r_sp_en    <= w_is_sprite;
                        r_addr     <= r_addr_cnt;
                        r_data     <= w_next_data;
                        r_addr_cnt <= r_addr_cnt + 17'd1;
                    end
                end
                FULL: begin
                    if (w_handshake) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign background_write_en  = r_bg_en;
    assign spritesheet_write_en = r_sp_en;
    assign image_write_addr     = r_addr;
    assign image_write_data     = r_data;
    assign busy                 = r_busy;
    assign done                 = r_done;
    assign overflow             = r_overflow;

endmodule
